// File: rtl/eth_tx_header_insert.sv
// Ethernet TX header inserter: prepends dst MAC, source MAC and ethertype to an
// AXI-Stream payload, shifting payload bytes two lanes to follow the 14-byte header.
module eth_tx_header_insert #(
  parameter logic [47:0] P_SRC_MAC = 48'h0A0B_0C0D_0E0F
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] s_axis_tdata,
  input  logic [79:0] s_axis_tuser,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_TAIL = 3'd4
  } state_t;

  state_t      state_r;
  logic [47:0] rem_r;
  logic [15:0] type_r;
  logic [7:0]  tail_keep_r;
  logic        free_s;
  logic        consume_s;
  logic [47:0] prefix_s;
  logic [63:0] pay_data_s;
  logic [7:0]  pay_keep_s;
  logic        pay_last_s;
  state_t      pay_next_s;
  logic        unused_s;

  function automatic logic [63:0] mask_lanes(input logic [63:0] data, input logic [7:0] keep);
    logic [63:0] res;
    res = 64'h0;
    for (int i = 0; i < 8; i++) begin
      if (keep[i]) begin
        res[i*8 +: 8] = data[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = 8'h00;
      end
    end
    return res;
  endfunction

  assign free_s    = ~m_axis_tvalid | m_axis_tready;
  assign consume_s = s_axis_tvalid & s_axis_tready;
  // The length field in tuser carries no information this block needs.
  assign unused_s  = ^s_axis_tuser[79:64];

  // Upstream ready as a function of state and output slot availability
  always_comb begin
    s_axis_tready = 1'b0;
    case (state_r)
      ST_IDLE: s_axis_tready = 1'b0;
      ST_HDR0: s_axis_tready = m_axis_tready;
      ST_HDR1: s_axis_tready = 1'b1;
      ST_DATA: s_axis_tready = free_s;
      ST_TAIL: s_axis_tready = 1'b0;
      default: s_axis_tready = 1'b0;
    endcase
  end

  // Realigned output beat formed from the carried-over bytes and the current input beat
  always_comb begin
    if (state_r == ST_DATA) begin
      prefix_s = rem_r;
    end else begin
      prefix_s = {P_SRC_MAC[31:0], type_r};
    end
    if (s_axis_tlast) begin
      if (s_axis_tkeep[5]) begin
        pay_keep_s = 8'hFF;
        pay_last_s = 1'b0;
        pay_next_s = ST_TAIL;
      end else begin
        // At most two bytes in the last beat: they fit alongside the carried six.
        pay_keep_s = {6'b11_1111, s_axis_tkeep[7:6]};
        pay_last_s = 1'b1;
        pay_next_s = ST_IDLE;
      end
    end else begin
      pay_keep_s = 8'hFF;
      pay_last_s = 1'b0;
      pay_next_s = ST_DATA;
    end
    pay_data_s = mask_lanes({prefix_s, s_axis_tdata[63:48]}, pay_keep_s);
  end

  // Framing FSM with registered output beat and frame counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= ST_IDLE;
      rem_r         <= 48'h0;
      type_r        <= 16'h0;
      tail_keep_r   <= 8'h00;
      m_axis_tdata  <= 64'h0;
      m_axis_tkeep  <= 8'h00;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      o_frame_cnt   <= 16'h0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (s_axis_tvalid && free_s) begin
            m_axis_tdata  <= {s_axis_tuser[63:16], P_SRC_MAC[47:32]};
            m_axis_tkeep  <= 8'hFF;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            type_r        <= s_axis_tuser[15:0];
            state_r       <= ST_HDR0;
          end else if (free_s) begin
            m_axis_tdata  <= 64'h0;
            m_axis_tkeep  <= 8'h00;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
          end
        end
        ST_HDR0, ST_HDR1, ST_DATA: begin
          if (consume_s) begin
            m_axis_tdata  <= pay_data_s;
            m_axis_tkeep  <= pay_keep_s;
            m_axis_tlast  <= pay_last_s;
            m_axis_tvalid <= 1'b1;
            rem_r         <= s_axis_tdata[47:0];
            tail_keep_r   <= {s_axis_tkeep[5:0], 2'b00};
            state_r       <= pay_next_s;
          end else if (free_s) begin
            m_axis_tdata  <= 64'h0;
            m_axis_tkeep  <= 8'h00;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            if (state_r == ST_HDR0) begin
              state_r <= ST_HDR1;
            end
          end
        end
        ST_TAIL: begin
          if (free_s) begin
            m_axis_tdata  <= mask_lanes({rem_r, 16'h0}, tail_keep_r);
            m_axis_tkeep  <= tail_keep_r;
            m_axis_tlast  <= 1'b1;
            m_axis_tvalid <= 1'b1;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
